// File: rtl/parity_frame_rx_4bit.sv
// Serial frame receiver: start, 4 data bits LSB first, parity, stop.
// Deserialises the nibble, reports the parity bit and an even/odd parity verdict.
module parity_frame_rx_4bit #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  input  logic       parity_mode,
  output logic [3:0] data,
  output logic       parity,
  output logic       error,
  output logic       frame_err,
  output logic       valid,
  output logic       busy,
  output logic [2:0] dbg_state_o
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    bit_q, bit_d;
  logic [3:0]    shift_q, shift_d;
  logic          par_rx_q, par_rx_d;
  logic          mode_q, mode_d;
  logic [3:0]    data_q, data_d;
  logic          parity_q, parity_d;
  logic          error_q, error_d;
  logic          frame_err_q, frame_err_d;
  logic          valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_rx_q    <= 1'b0;
      mode_q      <= 1'b0;
      data_q      <= '0;
      parity_q    <= 1'b0;
      error_q     <= 1'b0;
      frame_err_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_rx_q    <= par_rx_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      parity_q    <= parity_d;
      error_q     <= error_d;
      frame_err_q <= frame_err_d;
      valid_q     <= valid_d;
    end
  end

  // cnt_q counts cycles since the last sample point; samples fire on the terminal count.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_rx_d    = par_rx_q;
    mode_d      = mode_q;
    data_d      = data_q;
    parity_d    = parity_q;
    error_d     = error_q;
    frame_err_d = frame_err_q;
    valid_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!serial_in) begin
          state_d = START;
          bit_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!serial_in) begin
            state_d = DATA;
            mode_d  = parity_mode;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {serial_in, shift_q[3:1]};
          bit_d   = bit_q + 2'd1;
          if (bit_q == 2'd3) state_d = PARITY;
        end
      end
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          par_rx_d = serial_in;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d       = '0;
          data_d      = shift_q;
          parity_d    = par_rx_q;
          error_d     = (^shift_q) ^ par_rx_q ^ mode_q;
          frame_err_d = !serial_in;
          valid_d     = 1'b1;
          state_d     = serial_in ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (serial_in) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign data        = data_q;
  assign parity      = parity_q;
  assign error       = error_q;
  assign frame_err   = frame_err_q;
  assign valid       = valid_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_parity_frame_rx_4bit.sv
// Bench for parity_frame_rx_4bit: directed frame table, hand corner cases,
// random frames against a behavioural parity/framing model.
module tb_parity_frame_rx_4bit;

  localparam int CPB = 4;
  localparam int H   = CPB / 2;
  localparam int W   = 27;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial_in;
  logic       parity_mode;
  logic [3:0] data;
  logic       parity;
  logic       error;
  logic       frame_err;
  logic       valid;
  logic       busy;
  logic [2:0] dbg_state;

  parity_frame_rx_4bit #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .parity_mode(parity_mode),
    .data       (data),
    .parity     (parity),
    .error      (error),
    .frame_err  (frame_err),
    .valid      (valid),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic [6:0]   last_exp = '0;
  logic         valid_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Frame rules stated directly: odd total count of ones across data, parity bit
  // and mode flag means a parity error; a low stop bit means a framing error.
  function automatic logic [6:0] model(input logic [3:0] d, input logic p, input logic s,
                                       input logic m);
    int ones;
    ones = $countones(d) + int'(p) + int'(m);
    return {d, p, logic'(ones % 2), !s};
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      last_exp = '0;
    end else if (valid) begin
      check("valid_width", {31'd0, valid_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_valid actual=%0h expected=none at cycle %0d",
                 {data, parity, error, frame_err}, cyc);
      end else begin
        e = exp_q.pop_front();
        check("valid_cycle", cyc, {12'd0, e[26:7]});
        check("frame_fields", {25'd0, data, parity, error, frame_err}, {25'd0, e[6:0]});
        last_exp = e[6:0];
      end
    end else begin
      check("hold_outputs", {25'd0, data, parity, error, frame_err}, {25'd0, last_exp});
    end
    valid_prev = valid;
  end

  // ---------------- driver tasks (all keep phase at posedge+1) ----------------
  task automatic drive_bit(input logic b, input int n);
    serial_in = b;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic s, input logic m,
                            input logic tog, input int stop_len, input int hold,
                            input logic [6:0] exp);
    exp_q.push_back({20'(cyc + 27), exp});
    parity_mode = m;
    drive_bit(1'b0, CPB);
    if (tog) parity_mode = !m;
    for (int i = 0; i < 4; i++) drive_bit(d[i], CPB);
    drive_bit(p, CPB);
    drive_bit(s, stop_len);
    if (hold > 0) drive_bit(1'b0, hold);
    serial_in = 1'b1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0] d;
    logic       p;
    logic       s;
    logic       m;
    logic       tog;
    int         hold;
    logic [3:0] ed;
    logic       ep;
    logic       ee;
    logic       ef;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int busy_cnt;
    logic [3:0] rd;
    logic rp, rs, rm, rt;
    int rh, gap;

    vecs[0] = '{4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 0,  4'b0110, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 0,  4'b0110, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{4'b0110, 1'b1, 1'b1, 1'b1, 1'b0, 0,  4'b0110, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'b0110, 1'b0, 1'b1, 1'b1, 1'b0, 0,  4'b0110, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{4'b0110, 1'b1, 1'b1, 1'b1, 1'b1, 0,  4'b0110, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'b0110, 1'b1, 1'b1, 1'b0, 1'b1, 0,  4'b0110, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 0,  4'b0001, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 0,  4'b1011, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 10, 4'b0110, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 0,  4'b1001, 1'b0, 1'b0, 1'b0};

    rst_n       = 1'b0;
    serial_in   = 1'b1;
    parity_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, data, parity, error, frame_err, valid, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_bit(1'b1, 2);

    // table of directed frames
    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].d, vecs[i].p, vecs[i].s, vecs[i].m, vecs[i].tog, CPB, vecs[i].hold,
                 {vecs[i].ed, vecs[i].ep, vecs[i].ee, vecs[i].ef});
      drive_bit(1'b1, 3);
    end

    // glitch: one low cycle, expect busy for exactly H cycles and no valid
    busy_cnt = 0;
    serial_in = 1'b0;
    drive_bit(1'b0, 1);
    serial_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      busy_cnt += int'(busy);
    end
    check("glitch_busy_cycles", busy_cnt, H);
    @(posedge clk); #1;
    drive_bit(1'b1, 2);

    // minimum frame period: short stop bit, next start right after
    send_frame(4'b0101, 1'b0, 1'b1, 1'b0, 1'b0, H + 1, 0, model(4'b0101, 1'b0, 1'b1, 1'b0));
    send_frame(4'b1100, 1'b1, 1'b1, 1'b1, 1'b0, CPB, 0, model(4'b1100, 1'b1, 1'b1, 1'b1));
    drive_bit(1'b1, 3);

    // nonzero outputs before the reset test
    send_frame(4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, CPB, 0, {4'b1011, 1'b1, 1'b1, 1'b0});
    drive_bit(1'b1, 3);
    check("busy_idle_after_frame", {31'd0, busy}, 32'd0);

    // reset during data bit 2
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, 2);
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    serial_in = 1'b1;
    #1;
    check("async_reset_outputs", {26'd0, data, parity, error, frame_err, valid, busy}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    drive_bit(1'b1, 2);
    send_frame(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, CPB, 0, {4'b1111, 1'b0, 1'b0, 1'b0});
    drive_bit(1'b1, 3);

    // randomized frames against the model
    for (int i = 0; i < 24; i++) begin
      rd  = 4'($urandom_range(0, 15));
      rp  = 1'($urandom_range(0, 1));
      rm  = 1'($urandom_range(0, 1));
      rt  = 1'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 5) != 0);
      rh  = rs ? 0 : $urandom_range(0, 6);
      gap = rs ? $urandom_range(0, 4) : $urandom_range(1, 4);
      send_frame(rd, rp, rs, rm, rt, CPB, rh, model(rd, rp, rs, rm));
      drive_bit(1'b1, gap);
    end

    // drain: every expected frame must have appeared
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL missing_valid actual=none expected=%0h due_cycle=%0d", e[6:0], e[26:7]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parity_frame_rx_4bit.md
# parity_frame_rx_4bit

Serial front-end that receives one asynchronous-style frame (start bit, 4 data bits LSB first, parity bit, stop bit) on a single line and presents the deserialised nibble, the received parity bit and a parity verdict. It sits directly upstream of the 4-bit parity checker and produces exactly the data/parity/mode triple that block consumes. It also performs the same even/odd check internally, so frames can be flagged without an extra stage.

## Interface
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal range 2..256. H = CLKS_PER_BIT/2 (integer division).
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- serial_in  input  1  serial line, idle high, already synchronous to clk.
- parity_mode  input  1  0 = even parity, 1 = odd parity; sampled at the start-bit confirm.
- data  output  4  last received nibble; data[0] = first data bit on the line.
- parity  output  1  last received parity bit.
- error  output  1  parity error for the last frame.
- frame_err  output  1  stop bit sampled 0 for the last frame.
- valid  output  1  one-cycle pulse: data/parity/error/frame_err updated.
- busy  output  1  high while a frame is in progress (any state except IDLE).

## Operation
- Reset (async, rst_n=0): state=IDLE, counters 0; data=0, parity=0, error=0, frame_err=0, valid=0, busy=0.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: serial_in=0 at an edge -> START, bit counter cleared.
- START: after H cycles, resample serial_in. 0 -> DATA, latch parity_mode. 1 -> IDLE (glitch rejected, no valid).
- DATA: sample every CLKS_PER_BIT cycles, shifting into data[0]..data[3] in order. After the 4th sample -> PARITY.
- PARITY: sample after CLKS_PER_BIT cycles -> STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - Register outputs and pulse valid.
  - Stop=1 -> IDLE.
  - Stop=0 -> frame_err=1 and go to WAIT_HIGH.
- WAIT_HIGH: remain until serial_in=1, then IDLE. No new frame is armed while the line is held low.
- Parity check (latched mode m): error = (^data_rx ^ parity_rx) ^ m.
  - Even mode, 0110 with parity 0 -> error 0.
  - Odd mode, 0110 with parity 1 -> error 0.
- data/parity/error/frame_err hold their values until the next valid pulse.
- Intermediate shift values are never visible on outputs.
- A frame with frame_err=1 still reports data, parity and error.
- parity_mode changes mid-frame have no effect; only the value latched at start confirm is used.

## Timing
- Edge 0 = first edge sampling serial_in=0 in IDLE.
- busy is 1 after edge 0 and returns to 0 on the edge that leaves STOP/WAIT_HIGH for IDLE.
- Sample edges:
  - start confirm: edge H
  - data bit i (i=0..3): edge H+(i+1)·CLKS_PER_BIT
  - parity: edge H+5·CLKS_PER_BIT
  - stop: edge H+6·CLKS_PER_BIT
- Outputs update and valid rises on the stop-sample edge. valid falls on the next edge, so it is exactly 1 cycle wide.
- With CLKS_PER_BIT=4 (H=2): valid high for the cycle after edge 26.
- Back-to-back frames: a new start bit is accepted on the first edge after returning to IDLE. The minimum frame period is 6·CLKS_PER_BIT + H + 1 cycles.
- Reset asserted mid-frame: all outputs clear immediately, no valid is emitted, and the partial frame is discarded. After release, reception restarts from IDLE.

## Test plan
- Even parity, correct: CLKS_PER_BIT=4, mode=0, frame 0/0,1,1,0/0/1 (data 0110, parity 0). Expect valid pulse after edge 26, data=0110, parity=0, error=0, frame_err=0.
- Even parity, wrong: same frame with parity bit 1. Expect error=1, frame_err=0, data=0110.
- Odd parity: mode=1 with parity bit 1 -> error=0; then parity bit 0 -> error=1. Toggling parity_mode after start confirm changes nothing.
- Glitch rejection: serial_in low for 1 cycle, then high. Expect busy high for H cycles, then IDLE, valid never asserted.
- Framing error: stop bit 0, line held low 10 more cycles. Expect valid with frame_err=1 and no second frame. Line then goes high and a correct frame data=1001, parity=0, mode=0 is sent: expect error=0, frame_err=0.
- Reset mid-frame: assert rst_n=0 during data bit 2. Expect all outputs 0 asynchronously and no valid. After release, a full frame data=1111, parity=0, mode=0 gives error=0.
